// File: rtl/rv32_bus_arbiter.sv
// Shares one memory bus between fetch and data ports; data wins unless RV32_BUS_ARB_STARVATION_GUARD_EN forces fetch.
// Latency: grant registered, first bus strobe 1 cycle after request; *_ready_out combinational from ready_in.
// Backpressure: owner holds the bus until ready_in; an IDLE cycle always separates consecutive grants.
module rv32_bus_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset_,

    input  logic        instr_read_in,
    input  logic [31:0] instr_address_in,
    output logic        instr_ready_out,
    output logic [31:0] instr_read_value_out,

    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [31:0] data_address_in,
    input  logic [3:0]  data_write_mask_in,
    input  logic [31:0] data_write_value_in,
    output logic        data_ready_out,
    output logic [31:0] data_read_value_out,

    output logic [31:0] address_out,
    output logic        read_out,
    output logic        write_out,
    output logic [3:0]  write_mask_out,
    output logic [31:0] write_value_out,
    input  logic [31:0] read_value_in,
    input  logic        ready_in
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic data_req;
    logic starved;

    assign data_req = data_read_in | data_write_in;

    // A zero wait bound would let fetch pre-empt data on every IDLE cycle.
    if (MAX_WAIT < 1) begin : g_max_wait_invalid
    end

`ifdef RV32_BUS_ARB_STARVATION_GUARD_EN
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_cnt_q;

    assign starved = (wait_cnt_q == CW'(MAX_WAIT));

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wait_cnt_q <= '0;
        end else if (state_q == IDLE && state_d == INSTR) begin
            wait_cnt_q <= '0;
        end else if (instr_read_in && state_q != INSTR && !starved) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end
`else
    assign starved = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (data_req && !(instr_read_in && starved)) begin
                    state_d = DATA;
                end else if (instr_read_in) begin
                    state_d = INSTR;
                end
            end
            INSTR, DATA: begin
                // Completion ends the grant even if the owner has illegally dropped its request.
                if (ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        address_out     = 32'h0;
        read_out        = 1'b0;
        write_out       = 1'b0;
        write_mask_out  = 4'h0;
        write_value_out = 32'h0;
        instr_ready_out = 1'b0;
        data_ready_out  = 1'b0;
        case (state_q)
            INSTR: begin
                address_out     = instr_address_in;
                read_out        = instr_read_in;
                instr_ready_out = ready_in;
            end
            DATA: begin
                address_out     = data_address_in;
                write_out       = data_write_in;
                // A simultaneous read+write is treated as a store.
                read_out        = data_read_in & ~data_write_in;
                write_mask_out  = data_write_mask_in;
                write_value_out = data_write_value_in;
                data_ready_out  = ready_in;
            end
            default: ;
        endcase
    end

    assign instr_read_value_out = read_value_in;
    assign data_read_value_out  = read_value_in;

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Directed checks of the fetch/data bus arbiter: reset, single fetch, contention, store, starvation, idle bus.
module tb_rv32_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_;
    logic        instr_read_in;
    logic [31:0] instr_address_in;
    logic        instr_ready_out;
    logic [31:0] instr_read_value_out;
    logic        data_read_in;
    logic        data_write_in;
    logic [31:0] data_address_in;
    logic [3:0]  data_write_mask_in;
    logic [31:0] data_write_value_in;
    logic        data_ready_out;
    logic [31:0] data_read_value_out;
    logic [31:0] address_out;
    logic        read_out;
    logic        write_out;
    logic [3:0]  write_mask_out;
    logic [31:0] write_value_out;
    logic [31:0] read_value_in;
    logic        ready_in;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv32_bus_arbiter #(.MAX_WAIT(4)) dut (
        .clk                  (clk),
        .reset_               (reset_),
        .instr_read_in        (instr_read_in),
        .instr_address_in     (instr_address_in),
        .instr_ready_out      (instr_ready_out),
        .instr_read_value_out (instr_read_value_out),
        .data_read_in         (data_read_in),
        .data_write_in        (data_write_in),
        .data_address_in      (data_address_in),
        .data_write_mask_in   (data_write_mask_in),
        .data_write_value_in  (data_write_value_in),
        .data_ready_out       (data_ready_out),
        .data_read_value_out  (data_read_value_out),
        .address_out          (address_out),
        .read_out             (read_out),
        .write_out            (write_out),
        .write_mask_out       (write_mask_out),
        .write_value_out      (write_value_out),
        .read_value_in        (read_value_in),
        .ready_in             (ready_in)
    );

    // An owner must hold its request until its transaction completes.
    always @(negedge clk) begin
        if (reset_) begin
            if (dut.state_q == 2'd1)
                assert (instr_read_in) else $error("protocol: fetch request dropped while owning bus");
            if (dut.state_q == 2'd2)
                assert (data_read_in | data_write_in) else $error("protocol: data request dropped while owning bus");
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        instr_read_in       = 1'b0;
        instr_address_in    = 32'h0;
        data_read_in        = 1'b0;
        data_write_in       = 1'b0;
        data_address_in     = 32'h0;
        data_write_mask_in  = 4'h0;
        data_write_value_in = 32'h0;
        ready_in            = 1'b0;
    endtask

    initial begin
        int owned_instr;
        int busy;
        int cyc;
        logic [1:0] own;
        logic [1:0] exp_own [1:5];

        clear_inputs();
        read_value_in = 32'hA5A5_0001;
        reset_ = 1'b0;

        // Reset: everything quiet, pass-throughs follow the bus.
        ready_in = 1'b1;
        @(negedge clk);
        chk("rst_read_out", {31'b0, read_out}, 32'd0);
        chk("rst_write_out", {31'b0, write_out}, 32'd0);
        chk("rst_readies", {30'b0, instr_ready_out, data_ready_out}, 32'd0);
        chk("rst_address", address_out, 32'h0);
        chk("rst_instr_rv", instr_read_value_out, 32'hA5A5_0001);
        chk("rst_data_rv", data_read_value_out, 32'hA5A5_0001);
        ready_in = 1'b0;
        step();
        reset_ = 1'b1;
        step();

        // Single fetch with three bus cycles.
        instr_read_in = 1'b1; instr_address_in = 32'h100;
        @(negedge clk);
        chk("f_c0_read", {31'b0, read_out}, 32'd0);
        step();
        @(negedge clk);
        chk("f_c1_read", {31'b0, read_out}, 32'd1);
        chk("f_c1_addr", address_out, 32'h100);
        chk("f_c1_write", {31'b0, write_out}, 32'd0);
        step();
        @(negedge clk);
        chk("f_c2_read", {31'b0, read_out}, 32'd1);
        chk("f_c2_rdy", {31'b0, instr_ready_out}, 32'd0);
        step();
        ready_in = 1'b1; read_value_in = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("f_c3_rdy", {31'b0, instr_ready_out}, 32'd1);
        chk("f_c3_rv", instr_read_value_out, 32'hDEAD_BEEF);
        chk("f_c3_drdy", {31'b0, data_ready_out}, 32'd0);
        chk("f_c3_addr", address_out, 32'h100);
        step();
        instr_read_in = 1'b0; ready_in = 1'b0;
        @(negedge clk);
        chk("f_c4_read", {31'b0, read_out}, 32'd0);
        chk("f_c4_addr", address_out, 32'h0);
        step();

        // Simultaneous fetch and load: data first, fetch after an IDLE cycle.
        instr_read_in = 1'b1; instr_address_in = 32'h200;
        data_read_in = 1'b1; data_address_in = 32'h8000;
        ready_in = 1'b1;
        @(negedge clk);
        chk("s_c0_readies", {30'b0, instr_ready_out, data_ready_out}, 32'd0);
        step();
        @(negedge clk);
        chk("s_c1_addr", address_out, 32'h8000);
        chk("s_c1_readies", {30'b0, instr_ready_out, data_ready_out}, 32'd1);
        step();
        data_read_in = 1'b0;
        @(negedge clk);
        chk("s_c2_read", {31'b0, read_out}, 32'd0);
        chk("s_c2_readies", {30'b0, instr_ready_out, data_ready_out}, 32'd0);
        step();
        @(negedge clk);
        chk("s_c3_addr", address_out, 32'h200);
        chk("s_c3_readies", {30'b0, instr_ready_out, data_ready_out}, 32'd2);
        step();
        clear_inputs();
        step();

        // Store, then read+write asserted together mid-grant.
        data_write_in = 1'b1; data_address_in = 32'h8004;
        data_write_mask_in = 4'b0011; data_write_value_in = 32'h1234;
        step();
        @(negedge clk);
        chk("st_write", {31'b0, write_out}, 32'd1);
        chk("st_read", {31'b0, read_out}, 32'd0);
        chk("st_mask", {28'b0, write_mask_out}, 32'h3);
        chk("st_value", write_value_out, 32'h1234);
        chk("st_addr", address_out, 32'h8004);
        step();
        data_read_in = 1'b1;
        @(negedge clk);
        chk("rw_read", {31'b0, read_out}, 32'd0);
        chk("rw_write", {31'b0, write_out}, 32'd1);
        step();
        ready_in = 1'b1;
        @(negedge clk);
        chk("st_drdy", {31'b0, data_ready_out}, 32'd1);
        step();
        clear_inputs();
        step();

        // Reset asserted mid-load drops the strobe without waiting for a clock.
        data_read_in = 1'b1; data_address_in = 32'h40;
        step();
        @(negedge clk);
        chk("rm_read_before", {31'b0, read_out}, 32'd1);
        #1 reset_ = 1'b0;
        #1;
        chk("rm_read_async", {31'b0, read_out}, 32'd0);
        chk("rm_addr_async", address_out, 32'h0);
        ready_in = 1'b1;
        #1;
        chk("rm_drdy", {31'b0, data_ready_out}, 32'd0);
        step();
        clear_inputs();
        step();
        reset_ = 1'b1;
        step();

        // Idle bus with spurious ready_in.
        busy = 0;
        for (int i = 0; i < 10; i++) begin
            ready_in = i[0];
            @(negedge clk);
            if (read_out || write_out || instr_ready_out || data_ready_out || address_out != 0) busy++;
            step();
        end
        chk("idle_activity", busy, 0);
        ready_in = 1'b0;
        step();

        // Starvation: data requests continuously, fetch waiting.
        instr_read_in = 1'b1; instr_address_in = 32'h300;
        data_read_in = 1'b1; data_address_in = 32'h9000;
        ready_in = 1'b1;
`ifdef RV32_BUS_ARB_STARVATION_GUARD_EN
        exp_own = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd2};
`else
        exp_own = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
`endif
        step();
        for (cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            own = {instr_ready_out, data_ready_out};
            chk($sformatf("starve_c%0d_owner", cyc), {30'b0, own}, {30'b0, exp_own[cyc]});
            step();
        end
`ifndef RV32_BUS_ARB_STARVATION_GUARD_EN
        owned_instr = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (instr_ready_out) owned_instr++;
            step();
        end
        chk("starve_no_instr_100", owned_instr, 0);
`endif
        clear_inputs();
        step();
        @(negedge clk);
        chk("end_idle_read", {31'b0, read_out}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
